// File: rtl/knn_seq_if.sv
// Handshake and datapath-control bundle for the knn sequencer.
// The slave modport is the sequencer side; master is the CPU/DMA/datapath side.
interface knn_seq_if #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned NTRAIN_W = 16
);
    logic                start;
    logic [NTRAIN_W-1:0] n_train;
    logic                busy;
    logic                pass_done;
    logic [DATA_W-1:0]   tp_data;
    logic                tp_valid;
    logic                tp_ready;
    logic [DATA_W-1:0]   tr_data;
    logic                tr_valid;
    logic                tr_ready;
    logic [15:0]         res_data;
    logic [15:0]         res_solver;
    logic [15:0]         res_idx;
    logic                res_valid;
    logic                res_ready;
    logic                knn_rst;
    logic                knn_valid;
    logic                knn_done;
    logic [15:0]         knn_sel;
    logic [15:0]         knn_solver_sel;
    logic [DATA_W-1:0]   knn_data_1;
    logic [DATA_W-1:0]   knn_data_2;
    logic [15:0]         knn_data_out;

    modport slave (
        input  start, n_train, tp_data, tp_valid, tr_data, tr_valid, res_ready, knn_data_out,
        output busy, pass_done, tp_ready, tr_ready, res_data, res_solver, res_idx, res_valid,
               knn_rst, knn_valid, knn_done, knn_sel, knn_solver_sel, knn_data_1, knn_data_2
    );

    modport master (
        output start, n_train, tp_data, tp_valid, tr_data, tr_valid, res_ready, knn_data_out,
        input  busy, pass_done, tp_ready, tr_ready, res_data, res_solver, res_idx, res_valid,
               knn_rst, knn_valid, knn_done, knn_sel, knn_solver_sel, knn_data_1, knn_data_2
    );
endinterface

// File: rtl/knn_seq.sv
// knn solver-array sequencer: clear, load test points, stream training points,
// then read back every neighbour register of every solver onto the result stream.
module knn_seq #(
    parameter int unsigned N_SOLVERS = 4,
    parameter int unsigned HW_K      = 10,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned NTRAIN_W  = 16
) (
    input  logic     clk,
    input  logic     rst,
    knn_seq_if.slave bus
);
    localparam int unsigned SW = $clog2(N_SOLVERS) + 1;
    localparam int unsigned KW = $clog2(HW_K) + 1;

    localparam logic [3:0] IDLE    = 4'd0;
    localparam logic [3:0] CLEAR   = 4'd1;
    localparam logic [3:0] LOAD    = 4'd2;
    localparam logic [3:0] STREAM  = 4'd3;
    localparam logic [3:0] FLUSH   = 4'd4;
    localparam logic [3:0] RD_SET  = 4'd5;
    localparam logic [3:0] RD_CAP  = 4'd6;
    localparam logic [3:0] RD_HOLD = 4'd7;
    localparam logic [3:0] DONE_ST = 4'd8;

    logic [3:0]          state_q, state_d;
    logic [SW-1:0]       s_q, s_d;
    logic [KW-1:0]       k_q, k_d;
    logic [NTRAIN_W-1:0] t_q, t_d, n_q, n_d;
    logic                busy_q, busy_d, pass_done_q, pass_done_d;
    logic                tp_ready_q, tp_ready_d, tr_ready_q, tr_ready_d;
    logic [15:0]         res_data_q, res_data_d, res_solver_q, res_solver_d;
    logic [15:0]         res_idx_q, res_idx_d;
    logic                res_valid_q, res_valid_d;
    logic                knn_rst_q, knn_rst_d, knn_valid_q, knn_valid_d;
    logic                knn_done_q, knn_done_d;
    logic [15:0]         knn_sel_q, knn_sel_d, knn_solver_sel_q, knn_solver_sel_d;
    logic [DATA_W-1:0]   knn_data_1_q, knn_data_1_d, knn_data_2_q, knn_data_2_d;

    logic last_k, last_s;
    assign last_k = (k_q == KW'(HW_K - 1));
    assign last_s = (s_q == SW'(N_SOLVERS - 1));

    // Next-state and next-output logic; every output is the flop of its _d value.
    always_comb begin
        state_d          = state_q;
        s_d              = s_q;
        k_d              = k_q;
        t_d              = t_q;
        n_d              = n_q;
        busy_d           = busy_q;
        pass_done_d      = 1'b0;
        tp_ready_d       = tp_ready_q;
        tr_ready_d       = tr_ready_q;
        res_data_d       = res_data_q;
        res_solver_d     = res_solver_q;
        res_idx_d        = res_idx_q;
        res_valid_d      = res_valid_q;
        knn_rst_d        = 1'b0;
        knn_valid_d      = 1'b0;
        knn_done_d       = knn_done_q;
        knn_sel_d        = knn_sel_q;
        knn_solver_sel_d = knn_solver_sel_q;
        knn_data_1_d     = knn_data_1_q;
        knn_data_2_d     = knn_data_2_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    n_d        = bus.n_train;
                    t_d        = '0;
                    s_d        = '0;
                    k_d        = '0;
                    busy_d     = 1'b1;
                    knn_rst_d  = 1'b1;
                    knn_done_d = 1'b0;
                    state_d    = CLEAR;
                end
            end
            CLEAR: begin
                s_d        = '0;
                tp_ready_d = 1'b1;
                state_d    = LOAD;
            end
            LOAD: begin
                if (bus.tp_valid && tp_ready_q) begin
                    knn_solver_sel_d = 16'(s_q);
                    knn_data_1_d     = bus.tp_data;
                    s_d              = s_q + SW'(1);
                    if (last_s) begin
                        tp_ready_d = 1'b0;
                        if (n_q == '0) begin
                            state_d = FLUSH;
                        end else begin
                            tr_ready_d = 1'b1;
                            state_d    = STREAM;
                        end
                    end
                end
            end
            STREAM: begin
                // t only reaches n_q after the final accept, so the compare cannot wrap.
                if (bus.tr_valid && tr_ready_q) begin
                    knn_data_2_d = bus.tr_data;
                    knn_valid_d  = 1'b1;
                    t_d          = t_q + NTRAIN_W'(1);
                    if (t_q == n_q - NTRAIN_W'(1)) begin
                        tr_ready_d = 1'b0;
                        state_d    = FLUSH;
                    end
                end
            end
            FLUSH: begin
                knn_done_d = 1'b1;
                s_d        = '0;
                k_d        = '0;
                state_d    = RD_SET;
            end
            RD_SET: begin
                knn_solver_sel_d = 16'(s_q);
                knn_sel_d        = 16'(k_q);
                state_d          = RD_CAP;
            end
            RD_CAP: begin
                res_data_d   = bus.knn_data_out;
                res_solver_d = 16'(s_q);
                res_idx_d    = 16'(k_q);
                res_valid_d  = 1'b1;
                state_d      = RD_HOLD;
            end
            RD_HOLD: begin
                if (bus.res_ready) begin
                    res_valid_d = 1'b0;
                    if (last_k) begin
                        k_d = '0;
                        s_d = s_q + SW'(1);
                    end else begin
                        k_d = k_q + KW'(1);
                    end
                    if (last_k && last_s) begin
                        pass_done_d      = 1'b1;
                        busy_d           = 1'b0;
                        knn_done_d       = 1'b0;
                        knn_sel_d        = '0;
                        knn_solver_sel_d = '0;
                        state_d          = DONE_ST;
                    end else begin
                        state_d = RD_SET;
                    end
                end
            end
            DONE_ST: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= IDLE;
            s_q              <= '0;
            k_q              <= '0;
            t_q              <= '0;
            n_q              <= '0;
            busy_q           <= 1'b0;
            pass_done_q      <= 1'b0;
            tp_ready_q       <= 1'b0;
            tr_ready_q       <= 1'b0;
            res_data_q       <= '0;
            res_solver_q     <= '0;
            res_idx_q        <= '0;
            res_valid_q      <= 1'b0;
            knn_rst_q        <= 1'b0;
            knn_valid_q      <= 1'b0;
            knn_done_q       <= 1'b0;
            knn_sel_q        <= '0;
            knn_solver_sel_q <= '0;
            knn_data_1_q     <= '0;
            knn_data_2_q     <= '0;
        end else begin
            state_q          <= state_d;
            s_q              <= s_d;
            k_q              <= k_d;
            t_q              <= t_d;
            n_q              <= n_d;
            busy_q           <= busy_d;
            pass_done_q      <= pass_done_d;
            tp_ready_q       <= tp_ready_d;
            tr_ready_q       <= tr_ready_d;
            res_data_q       <= res_data_d;
            res_solver_q     <= res_solver_d;
            res_idx_q        <= res_idx_d;
            res_valid_q      <= res_valid_d;
            knn_rst_q        <= knn_rst_d;
            knn_valid_q      <= knn_valid_d;
            knn_done_q       <= knn_done_d;
            knn_sel_q        <= knn_sel_d;
            knn_solver_sel_q <= knn_solver_sel_d;
            knn_data_1_q     <= knn_data_1_d;
            knn_data_2_q     <= knn_data_2_d;
        end
    end

    assign bus.busy           = busy_q;
    assign bus.pass_done      = pass_done_q;
    assign bus.tp_ready       = tp_ready_q;
    assign bus.tr_ready       = tr_ready_q;
    assign bus.res_data       = res_data_q;
    assign bus.res_solver     = res_solver_q;
    assign bus.res_idx        = res_idx_q;
    assign bus.res_valid      = res_valid_q;
    assign bus.knn_rst        = knn_rst_q;
    assign bus.knn_valid      = knn_valid_q;
    assign bus.knn_done       = knn_done_q;
    assign bus.knn_sel        = knn_sel_q;
    assign bus.knn_solver_sel = knn_solver_sel_q;
    assign bus.knn_data_1     = knn_data_1_q;
    assign bus.knn_data_2     = knn_data_2_q;
endmodule

// File: tb/tb_knn_seq.sv
// Randomised bench for knn_seq: a stimulus process drives passes with stalls,
// backpressure, stray starts and a mid-pass reset; a monitor checks every cycle.
module tb_knn_seq;
    localparam int NS = 4;
    localparam int HK = 10;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    knn_seq_if #(.DATA_W(32), .NTRAIN_W(16)) bus ();

    knn_seq #(.N_SOLVERS(NS), .HW_K(HK), .DATA_W(32), .NTRAIN_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Neighbour-register contents the datapath stub presents for (solver, index).
    function automatic logic [15:0] dp(input int s, input int k, input logic [15:0] sl);
        return 16'(32'h1000 + s * 256 + k * 3) ^ sl;
    endfunction

    logic [15:0] salt;
    assign bus.knn_data_out = dp(int'(bus.knn_solver_sel), int'(bus.knn_sel), salt);

    int exp_n;
    int tmo_events;
    bit end_req;

    // ---------------- monitor / scoreboard ----------------
    int tests, fails;
    int tp_cnt, tr_cnt, kv_cnt, res_cnt, krst_cnt, pass_idx;
    logic [31:0] trq[$];
    bit          tp_pend, hold_prev, chk_rst;
    logic [31:0] tp_word;
    int          tp_idx;
    logic [47:0] prev_res;
    logic [15:0] first_res, last_res;
    logic [151:0] outs;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic clear_pass();
        tp_cnt = 0; tr_cnt = 0; kv_cnt = 0; res_cnt = 0; krst_cnt = 0;
        trq.delete();
        tp_pend = 0; hold_prev = 0;
    endtask

    always @(negedge clk) begin
        outs = {bus.busy, bus.pass_done, bus.tp_ready, bus.tr_ready, bus.res_data,
                bus.res_solver, bus.res_idx, bus.res_valid, bus.knn_rst, bus.knn_valid,
                bus.knn_done, bus.knn_sel, bus.knn_solver_sel, bus.knn_data_1, bus.knn_data_2};
        if (chk_rst) begin
            check("reset_outputs_nonzero", 64'(|outs), 64'd0);
            chk_rst = 0;
        end
        if (rst) begin
            chk_rst = 1;
            clear_pass();
        end else begin
            if (tp_pend) begin
                check("load_word", {bus.knn_solver_sel, bus.knn_data_1}, {16'(tp_idx), tp_word});
                tp_pend = 0;
            end
            if (bus.knn_rst) krst_cnt++;
            if (bus.knn_valid) begin
                kv_cnt++;
                if (trq.size() == 0) check("knn_valid_without_accept", 64'd1, 64'd0);
                else check("train_word", 64'(bus.knn_data_2), 64'(trq.pop_front()));
            end
            if (bus.tp_valid && bus.tp_ready) begin
                tp_pend = 1; tp_word = bus.tp_data; tp_idx = tp_cnt; tp_cnt++;
            end
            if (bus.tr_valid && bus.tr_ready) begin
                trq.push_back(bus.tr_data); tr_cnt++;
            end
            if (hold_prev)
                check("result_held", {bus.res_valid, bus.res_solver, bus.res_idx, bus.res_data},
                      {1'b1, prev_res});
            hold_prev = bus.res_valid && !bus.res_ready;
            prev_res  = {bus.res_solver, bus.res_idx, bus.res_data};
            if (bus.res_valid && bus.res_ready) begin
                check("result", {bus.res_solver, bus.res_idx, bus.res_data, bus.knn_done},
                      {16'(res_cnt / HK), 16'(res_cnt % HK), dp(res_cnt / HK, res_cnt % HK, salt), 1'b1});
                if (res_cnt == 0) first_res = bus.res_data;
                if (res_cnt == NS * HK - 1) last_res = bus.res_data;
                res_cnt++;
            end
            if (bus.pass_done) begin
                check("busy_at_done", 64'(bus.busy), 64'd0);
                check("sel_cleared_at_done", {bus.knn_done, bus.knn_sel, bus.knn_solver_sel}, 64'd0);
                check("tp_accepts", 64'(tp_cnt), 64'(NS));
                check("tr_accepts", 64'(tr_cnt), 64'(exp_n));
                check("knn_valid_pulses", 64'(kv_cnt), 64'(exp_n));
                check("result_count", 64'(res_cnt), 64'(NS * HK));
                check("knn_rst_pulses", 64'(krst_cnt), 64'd1);
                if (pass_idx == 0) begin
                    check("pin_nominal_valid_pulses", 64'(kv_cnt), 64'd6);
                    check("pin_nominal_results", 64'(res_cnt), 64'd40);
                    check("pin_first_result", 64'(first_res), 64'h1000);
                    check("pin_last_result", 64'(last_res), 64'h131B);
                end
                pass_idx++;
                clear_pass();
            end
        end
        if (end_req) begin
            check("timeouts", 64'(tmo_events), 64'd0);
            check("passes_completed", 64'(pass_idx), 64'd10);
            $display("[TB] %0d tests run, %0d failed", tests, fails);
            $finish;
        end
    end

    // ---------------- stimulus ----------------
    task automatic run_pass(input int n, input bit tpm, input bit trm, input bit bp,
                            input int abort_at, input bit stray, input logic [15:0] sl);
        int cyc, trc, rcnt, hold;
        bit tp_acc, tr_acc, res_acc, done_seen;
        salt = sl;
        exp_n = n;
        cyc = 0; trc = 0; rcnt = 0; hold = 0; done_seen = 0;
        bus.n_train  = 16'(n);
        bus.start    = 1'b1;
        bus.tp_data  = $urandom;
        bus.tp_valid = 1'b1;
        bus.tr_data  = $urandom;
        bus.tr_valid = trm ? 1'b0 : 1'b1;
        bus.res_ready = bp ? 1'b0 : 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        if (stray) bus.n_train = 16'd3;
        while (!done_seen && cyc < 3000) begin
            @(negedge clk);
            tp_acc    = bus.tp_valid && bus.tp_ready;
            tr_acc    = bus.tr_valid && bus.tr_ready;
            res_acc   = bus.res_valid && bus.res_ready;
            done_seen = bus.pass_done;
            if (bus.res_valid && !bus.res_ready) hold++;
            if (res_acc) begin hold = 0; rcnt++; end
            if (tr_acc) trc++;
            @(posedge clk); #1;
            bus.start = 1'b0;
            if (abort_at > 0 && tr_acc && trc == abort_at) begin
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                bus.tp_valid = 1'b0; bus.tr_valid = 1'b0; bus.res_ready = 1'b0;
                repeat (3) @(posedge clk); #1;
                return;
            end
            if (tp_acc || !bus.tp_valid) begin
                bus.tp_data  = $urandom;
                bus.tp_valid = tpm ? ($urandom_range(0, 2) != 0) : 1'b1;
            end
            if (tr_acc || !bus.tr_valid) begin
                bus.tr_data  = $urandom;
                bus.tr_valid = trm ? (cyc % 3 == 0) : 1'b1;
            end
            bus.res_ready = bp ? (hold >= 5) : 1'b1;
            if (stray && (cyc == 3 || (res_acc && rcnt == 10))) bus.start = 1'b1;
            cyc++;
        end
        if (!done_seen) tmo_events++;
        bus.tp_valid = 1'b0; bus.tr_valid = 1'b0; bus.res_ready = 1'b0;
        repeat (2) @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1;
        bus.start = 1'b0; bus.n_train = '0;
        bus.tp_data = '0; bus.tp_valid = 1'b0;
        bus.tr_data = '0; bus.tr_valid = 1'b0;
        bus.res_ready = 1'b0;
        salt = '0; exp_n = 0; tmo_events = 0; end_req = 0;
        tests = 0; fails = 0; pass_idx = 0; chk_rst = 0;
        repeat (3) @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk); #1;

        run_pass(6, 0, 0, 0, 0, 0, 16'h0000);             // nominal
        run_pass(6, 1, 1, 0, 0, 0, 16'($urandom));        // tp gaps, tr 1-of-3
        run_pass(5, 0, 0, 1, 0, 0, 16'($urandom));        // result backpressure
        run_pass(0, 0, 0, 0, 0, 0, 16'($urandom));        // no training points
        run_pass(8, 0, 1, 0, 3, 0, 16'($urandom));        // reset after 3 accepts
        run_pass(4, 0, 0, 0, 0, 0, 16'($urandom));        // clean pass after reset
        run_pass(7, 1, 0, 0, 0, 1, 16'($urandom));        // stray starts in LOAD and READ
        for (int i = 0; i < 4; i++)
            run_pass($urandom_range(1, 12), 1'($urandom), 1'($urandom), 1'($urandom),
                     0, 1'($urandom), 16'($urandom));
        end_req = 1;
        repeat (3) @(posedge clk);
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish, want finish before 800000");
        $fatal(1, "watchdog");
    end
endmodule
